// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port around dmem_arbiter.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_wstrb;
  logic              c_gnt;
  logic              c_rvalid;
  logic [31:0]       c_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              m_en;
  logic [3:0]        m_we;
  logic [MEM_AW-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_wstrb,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_wstrb,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst limit sharing one single-port data memory
// between the core (C) and the debug/loader port (D); read data returns one cycle later.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_AW    = 10,
  parameter int BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic       OWN_C     = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic [3:0] CNT_SAT   = 4'd15;

  logic       last_owner_q, last_owner_d;
  logic [3:0] burst_cnt_q,  burst_cnt_d;
  logic       rsel_q,       rsel_d;
  logic       c_rvalid_q,   c_rvalid_d;
  logic       d_rvalid_q,   d_rvalid_d;
  logic       gnt_c_s;
  logic       gnt_d_s;
  logic       gnt_any_s;
  logic       gnt_we_s;

  // Arbitration state and read-return registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_D;
      burst_cnt_q  <= 4'd0;
      rsel_q       <= OWN_C;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rsel_q       <= rsel_d;
      c_rvalid_q   <= c_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // Grant decision; a zero burst count means no burst in progress, so plain round-robin applies
  always_comb begin
    gnt_c_s = 1'b0;
    gnt_d_s = 1'b0;
    if (!rst_n) begin
      gnt_c_s = 1'b0;
      gnt_d_s = 1'b0;
    end else if (bus.c_req && bus.d_req) begin
      if ((burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_LIM)) begin
        gnt_c_s = (last_owner_q == OWN_C);
        gnt_d_s = (last_owner_q == OWN_D);
      end else begin
        gnt_c_s = (last_owner_q == OWN_D);
        gnt_d_s = (last_owner_q == OWN_C);
      end
    end else begin
      gnt_c_s = bus.c_req;
      gnt_d_s = bus.d_req;
    end
  end

  assign gnt_any_s = gnt_c_s | gnt_d_s;
  assign gnt_we_s  = gnt_d_s ? bus.d_we : bus.c_we;

  // Next-state: burst counting, owner tracking and read-return bookkeeping
  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rsel_d       = rsel_q;
    c_rvalid_d   = gnt_c_s & ~bus.c_we;
    d_rvalid_d   = gnt_d_s & ~bus.d_we;
    if (gnt_any_s) begin
      if (gnt_d_s == last_owner_q) begin
        burst_cnt_d = (burst_cnt_q == CNT_SAT) ? CNT_SAT : (burst_cnt_q + 4'd1);
      end else begin
        last_owner_d = gnt_d_s;
        burst_cnt_d  = 4'd1;
      end
      if (!gnt_we_s) begin
        rsel_d = gnt_d_s;
      end else begin
        rsel_d = rsel_q;
      end
    end else if (!bus.c_req && !bus.d_req) begin
      burst_cnt_d = 4'd0;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  // Memory command mux and read-data steering
  always_comb begin
    bus.c_gnt    = gnt_c_s;
    bus.d_gnt    = gnt_d_s;
    bus.c_rvalid = c_rvalid_q;
    bus.d_rvalid = d_rvalid_q;
    bus.m_en     = gnt_any_s;
    bus.m_we     = 4'b0000;
    bus.m_addr   = '0;
    bus.m_wdata  = 32'd0;
    if (gnt_d_s) begin
      bus.m_addr  = bus.d_addr[MEM_AW+1:2];
      bus.m_wdata = bus.d_wdata;
      bus.m_we    = bus.d_we ? bus.d_wstrb : 4'b0000;
    end else if (gnt_c_s) begin
      bus.m_addr  = bus.c_addr[MEM_AW+1:2];
      bus.m_wdata = bus.c_wdata;
      bus.m_we    = bus.c_we ? bus.c_wstrb : 4'b0000;
    end else begin
      bus.m_addr  = '0;
      bus.m_wdata = 32'd0;
      bus.m_we    = 4'b0000;
    end
    bus.c_rdata = (c_rvalid_q && (rsel_q == OWN_C)) ? bus.m_rdata : 32'd0;
    bus.d_rdata = (d_rvalid_q && (rsel_q == OWN_D)) ? bus.m_rdata : 32'd0;
  end

endmodule
